// File: rtl/hsv_core_fetch.sv
// Instruction fetch stage: sequential PC walker issuing word reads, with an in-order,
// credit-limited response FIFO feeding decode and core-wide flush/redirect support.

package hsv_core_fetch_pkg;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic        fault;
    } fetch_data_t;

    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_HOLD = 1'b1
    } req_state_t;

endpackage

module hsv_core_fetch
    import hsv_core_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_core,
    input  logic        rst_core,
    input  logic        flush_req,
    input  logic [31:0] flush_pc,
    output logic        flush_ack,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_error,
    input  logic        ready_i,
    output logic        valid_o,
    output fetch_data_t fetch_data,
    output req_state_t  dbg_req_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // once the request channel raises valid, valid and addr stay put until ready is seen.

    localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_SUM = (CW + 1)'(FIFO_DEPTH);

    req_state_t  r_req_state;
    logic [31:0] r_pc;
    logic [31:0] r_rsp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    fetch_data_t r_mem [FIFO_DEPTH];

    req_state_t  w_req_state_next;
    logic        w_req_valid;
    logic        w_credit;
    logic        w_req_fire;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_flush_target;

    assign w_credit       = ({1'b0, r_outstanding} + {1'b0, r_count}) < DEPTH_SUM;
    assign w_flush_target = flush_pc & ~32'h3;

    always_comb begin
        w_req_state_next = r_req_state;
        w_req_valid      = 1'b0;
        unique case (r_req_state)
            REQ_IDLE: begin
                if (w_credit && !flush_req) begin
                    w_req_valid = 1'b1;
                    if (!mem_req_ready) w_req_state_next = REQ_HOLD;
                end
            end
            REQ_HOLD: begin
                // Already committed to this address; a flush must wait for acceptance.
                w_req_valid = 1'b1;
                if (mem_req_ready) w_req_state_next = REQ_IDLE;
            end
            default: w_req_state_next = REQ_IDLE;
        endcase
    end

    assign mem_req_valid = w_req_valid & ~rst_core;
    assign mem_req_addr  = r_pc;
    assign w_req_fire    = mem_req_valid & mem_req_ready;
    assign w_push        = mem_rsp_valid & ~flush_req;
    assign valid_o       = (r_count != '0) & ~flush_req;
    assign w_pop         = valid_o & ready_i;
    assign fetch_data    = r_mem[r_rd_ptr];
    assign flush_ack     = flush_req & (r_outstanding == '0) & ~mem_req_valid;
    assign dbg_req_state = r_req_state;

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            r_req_state   <= REQ_IDLE;
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_req_state <= w_req_state_next;

            if (flush_ack) begin
                r_pc     <= w_flush_target;
                r_rsp_pc <= w_flush_target;
            end else begin
                if (w_req_fire) r_pc <= r_pc + 32'd4;
                if (w_push)     r_rsp_pc <= r_rsp_pc + 32'd4;
            end

            case ({w_req_fire, mem_rsp_valid})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            if (flush_req) begin
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Faulting responses carry a zero instruction word so decode never sees bus garbage.
    always_ff @(posedge clk_core) begin
        if (!rst_core && w_push) begin
            r_mem[r_wr_ptr] <= '{insn:  mem_rsp_error ? 32'h0 : mem_rsp_data,
                                 pc:    r_rsp_pc,
                                 fault: mem_rsp_error};
        end
    end

    always_ff @(posedge clk_core) begin
        if (!rst_core) begin
            if (w_push)        assert (r_count != CW'(FIFO_DEPTH));
            if (mem_rsp_valid) assert (r_outstanding != '0);
        end
    end

endmodule

// File: tb/tb_hsv_core_fetch.sv
// Bench for hsv_core_fetch: memory model plus scoreboard on the decode stream,
// with scenario tasks for reset, streaming, backpressure, faults, flushes and PC wrap.

module tb_hsv_core_fetch;
    import hsv_core_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk_core = 1'b0;
    logic        rst_core = 1'b1;
    logic        flush_req = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        flush_ack;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic        mem_rsp_error = 1'b0;
    logic        ready_i = 1'b0;
    logic        valid_o;
    fetch_data_t fetch_data;
    req_state_t  dbg_req_state;

    always #5 clk_core = ~clk_core;

    hsv_core_fetch #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_core      (clk_core),
        .rst_core      (rst_core),
        .flush_req     (flush_req),
        .flush_pc      (flush_pc),
        .flush_ack     (flush_ack),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_error (mem_rsp_error),
        .ready_i       (ready_i),
        .valid_o       (valid_o),
        .fetch_data    (fetch_data),
        .dbg_req_state (dbg_req_state)
    );

    int n_cmp = 0;
    int n_err = 0;

    int          lat = 1;
    bit          mem_rand = 1'b0;
    bit          mem_rdy = 1'b1;
    bit          dec_rand = 1'b0;
    bit          dec_rdy = 1'b1;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [64:0] exp_q[$];
    fetch_data_t got_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] exp_req_addr = RST_PC;
    int          cyc = 0;
    int          first_acc = -1;
    int          first_vo = -1;
    int          n_pops = 0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory model and scoreboard: inputs are driven on the falling edge, outputs sampled 1 later.
    initial begin : mem_and_monitor
        pend_t       p;
        int          out_before;
        int          exp_before;
        logic        exp_ack;
        logic        exp_vo;
        logic [64:0] e;
        logic [31:0] w;
        forever begin
            @(negedge clk_core);
            if (rst_core) begin
                mem_rsp_valid = 1'b0;
                mem_rsp_error = 1'b0;
                mem_req_ready = 1'b0;
                ready_i       = 1'b0;
                pend_q.delete();
                exp_q.delete();
                exp_req_addr  = RST_PC;
                cyc           = 0;
                first_acc     = -1;
                first_vo      = -1;
                prev_hold     = 1'b0;
            end else begin
                out_before    = pend_q.size();
                exp_before    = exp_q.size();
                mem_req_ready = mem_rand ? 1'($urandom_range(0, 1)) : mem_rdy;
                ready_i       = dec_rand ? 1'($urandom_range(0, 1)) : dec_rdy;
                if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                    p = pend_q.pop_front();
                    w = mem_word(p.addr);
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = w;
                    mem_rsp_error = err_en && (p.addr == err_addr);
                    if (!flush_req)
                        exp_q.push_back({(mem_rsp_error ? 32'h0 : w), p.addr, mem_rsp_error});
                end else begin
                    mem_rsp_valid = 1'b0;
                    mem_rsp_error = 1'b0;
                    mem_rsp_data  = $urandom;
                end
                #1;
                exp_ack = flush_req && (out_before == 0) && !mem_req_valid;
                n_cmp++;
                if (flush_ack !== exp_ack) begin
                    n_err++;
                    $display("FAIL flush_ack cyc=%0d: got %b expected %b", cyc, flush_ack, exp_ack);
                end
                exp_vo = (exp_before > 0) && !flush_req;
                n_cmp++;
                if (valid_o !== exp_vo) begin
                    n_err++;
                    $display("FAIL valid_o cyc=%0d: got %b expected %b", cyc, valid_o, exp_vo);
                end
                if (prev_hold) begin
                    n_cmp++;
                    if (mem_req_valid !== 1'b1 || mem_req_addr !== prev_addr) begin
                        n_err++;
                        $display("FAIL req_hold cyc=%0d: got valid=%b addr=%h expected valid=1 addr=%h",
                                 cyc, mem_req_valid, mem_req_addr, prev_addr);
                    end
                end
                if (valid_o === 1'b1 && first_vo < 0) first_vo = cyc;
                if (valid_o === 1'b1 && ready_i) begin
                    n_cmp++;
                    n_pops++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL fetch_data cyc=%0d: got %h expected no entry", cyc, fetch_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (fetch_data !== e) begin
                            n_err++;
                            $display("FAIL fetch_data cyc=%0d: got %h expected %h", cyc, fetch_data, e);
                        end
                    end
                    got_q.push_back(fetch_data);
                end
                if (mem_req_valid === 1'b1 && mem_req_ready) begin
                    n_cmp++;
                    if (mem_req_addr !== exp_req_addr) begin
                        n_err++;
                        $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, mem_req_addr, exp_req_addr);
                    end
                    pend_q.push_back('{mem_req_addr, cyc + lat});
                    acc_log.push_back(mem_req_addr);
                    exp_req_addr = mem_req_addr + 32'd4;
                    if (first_acc < 0) first_acc = cyc;
                end
                if (flush_ack === 1'b1) exp_req_addr = flush_pc & ~32'h3;
                if (flush_req) exp_q.delete();
                prev_hold = (mem_req_valid === 1'b1) && !mem_req_ready;
                prev_addr = mem_req_addr;
                cyc++;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_core);
        #1;
    endtask

    task automatic reset_dut();
        @(posedge clk_core);
        #1;
        rst_core  = 1'b1;
        flush_req = 1'b0;
        repeat (2) @(posedge clk_core);
        #1;
        rst_core = 1'b0;
        got_q.delete();
        acc_log.delete();
    endtask

    // Waits for flush_ack, then drops flush_req in the following cycle.
    task automatic wait_ack(output int waited);
        waited = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_core);
            #2;
            if (flush_ack === 1'b1) begin
                waited = i;
                break;
            end
        end
        n_cmp++;
        if (waited < 0) begin
            n_err++;
            $display("FAIL flush_ack_timeout: got no ack expected ack within 50 cycles");
        end
        @(posedge clk_core);
        #1;
        flush_req = 1'b0;
        acc_log.delete();
        got_q.delete();
    endtask

    task automatic do_flush(input logic [31:0] tgt, output int waited);
        flush_pc  = tgt;
        flush_req = 1'b1;
        #1;
        n_cmp++;
        if (valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL valid_o_on_flush: got %b expected 0", valid_o);
        end
        wait_ack(waited);
    endtask

    task automatic check_addr(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        lat = 1; mem_rdy = 1'b1; dec_rdy = 1'b1;
        @(posedge clk_core);
        #1;
        rst_core = 1'b1;
        @(posedge clk_core);
        #1;
        n_cmp += 4;
        if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b expected 0", mem_req_valid); end
        if (valid_o !== 1'b0)       begin n_err++; $display("FAIL rst_valid_o: got %b expected 0", valid_o); end
        if (flush_ack !== 1'b0)     begin n_err++; $display("FAIL rst_flush_ack: got %b expected 0", flush_ack); end
        if (mem_req_addr !== RST_PC) begin n_err++; $display("FAIL rst_addr: got %h expected %h", mem_req_addr, RST_PC); end
        @(posedge clk_core);
        #1;
        rst_core = 1'b0;
        got_q.delete();
        acc_log.delete();
        @(negedge clk_core);
        #2;
        n_cmp++;
        if (mem_req_valid !== 1'b1) begin
            n_err++;
            $display("FAIL first_req: got %b expected 1", mem_req_valid);
        end
    endtask

    task automatic test_stream();
        int n0;
        cycles(20);
        n_cmp++;
        if (first_acc != 0 || first_vo - first_acc != 2) begin
            n_err++;
            $display("FAIL first_latency: got acc=%0d vo=%0d expected acc=0 vo=2", first_acc, first_vo);
        end
        check_addr("stream_pc0", got_q[0].pc, RST_PC);
        check_addr("stream_pc1", got_q[1].pc, RST_PC + 32'd4);
        n0 = got_q.size();
        cycles(16);
        n_cmp++;
        if (got_q.size() - n0 != 16) begin
            n_err++;
            $display("FAIL throughput: got %0d expected 16", got_q.size() - n0);
        end
    endtask

    task automatic test_backpressure();
        dec_rdy = 1'b0;
        reset_dut();
        cycles(12);
        n_cmp += 3;
        if (acc_log.size() != 4) begin n_err++; $display("FAIL bp_accepts: got %0d expected 4", acc_log.size()); end
        if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL bp_req_valid: got %b expected 0", mem_req_valid); end
        if (got_q.size() != 0) begin n_err++; $display("FAIL bp_pops: got %0d expected 0", got_q.size()); end
        acc_log.delete();
        dec_rdy = 1'b1;
        cycles(12);
        if (acc_log.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL bp_resume: got no request expected %h", 32'h110);
        end else begin
            check_addr("bp_resume", acc_log[0], 32'h0000_0110);
        end
        for (int i = 0; i < 4; i++)
            check_addr("bp_drain_pc", (got_q.size() > i) ? got_q[i].pc : 32'hDEAD_DEAD, RST_PC + 32'(4 * i));
    endtask

    task automatic test_fault();
        int idx;
        dec_rdy = 1'b1; err_en = 1'b1; err_addr = 32'h0000_0108;
        reset_dut();
        cycles(12);
        err_en = 1'b0;
        idx = -1;
        for (int i = 0; i < got_q.size(); i++)
            if (got_q[i].pc == 32'h0000_0108 && idx < 0) idx = i;
        n_cmp += 2;
        if (idx < 0 || idx + 1 >= got_q.size()) begin
            n_err++;
            $display("FAIL fault_entry: got no entry expected pc %h", 32'h108);
        end else begin
            if (got_q[idx].fault !== 1'b1 || got_q[idx].insn !== 32'h0) begin
                n_err++;
                $display("FAIL fault_entry: got fault=%b insn=%h expected fault=1 insn=0",
                         got_q[idx].fault, got_q[idx].insn);
            end
            if (got_q[idx+1].pc !== 32'h0000_010C || got_q[idx+1].fault !== 1'b0) begin
                n_err++;
                $display("FAIL fault_next: got pc=%h fault=%b expected pc=10c fault=0",
                         got_q[idx+1].pc, got_q[idx+1].fault);
            end
        end
    endtask

    task automatic test_flush();
        int waited;
        int exp_wait;
        lat = 3;
        reset_dut();
        cycles(10);
        exp_wait = (pend_q.size() == 0) ? 0 : pend_q[pend_q.size()-1].due + 1 - cyc;
        do_flush(32'h0000_2002, waited);
        n_cmp++;
        if (waited != exp_wait) begin
            n_err++;
            $display("FAIL flush_wait: got %0d expected %0d", waited, exp_wait);
        end
        cycles(10);
        check_addr("flush_first_req", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_DEAD, 32'h0000_2000);
        check_addr("flush_first_pc", (got_q.size() > 0) ? got_q[0].pc : 32'hDEAD_DEAD, 32'h0000_2000);
    endtask

    task automatic test_flush_hold();
        int waited;
        lat = 1; mem_rdy = 1'b0;
        reset_dut();
        cycles(3);
        flush_pc  = 32'h0000_3000;
        flush_req = 1'b1;
        cycles(3);
        n_cmp += 2;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin
            n_err++;
            $display("FAIL hold_under_flush: got valid=%b addr=%h expected valid=1 addr=%h",
                     mem_req_valid, mem_req_addr, RST_PC);
        end
        if (flush_ack !== 1'b0) begin
            n_err++;
            $display("FAIL early_ack: got %b expected 0", flush_ack);
        end
        mem_rdy = 1'b1;
        wait_ack(waited);
        n_cmp++;
        if (waited != 2) begin
            n_err++;
            $display("FAIL hold_ack_wait: got %0d expected 2", waited);
        end
        cycles(6);
        check_addr("hold_redirect", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_DEAD, 32'h0000_3000);
    endtask

    task automatic test_wrap();
        int waited;
        logic [31:0] exp_w [3];
        exp_w = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        do_flush(32'hFFFF_FFF8, waited);
        cycles(8);
        for (int i = 0; i < 3; i++) begin
            check_addr("wrap_req", (acc_log.size() > i) ? acc_log[i] : 32'hDEAD_DEAD, exp_w[i]);
            check_addr("wrap_pc", (got_q.size() > i) ? got_q[i].pc : 32'hDEAD_DEAD, exp_w[i]);
        end
    endtask

    task automatic test_back_to_back();
        int waited;
        int n0;
        lat = 2; mem_rand = 1'b1; dec_rand = 1'b1;
        n0 = n_pops;
        cycles(150);
        do_flush(32'h4000_0010, waited);
        cycles(150);
        mem_rand = 1'b0; dec_rand = 1'b0;
        cycles(5);
        n_cmp++;
        if (n_pops - n0 < 40) begin
            n_err++;
            $display("FAIL random_progress: got %0d pops expected at least 40", n_pops - n0);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin : main
        test_reset();
        test_stream();
        test_backpressure();
        test_fault();
        test_flush();
        test_flush_hold();
        test_wrap();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
